// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, R-type funct codes, COP0 sub-ops and the
// destination-select type used by the register-access decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [4:0] CP0_MF = 5'b00000;
  localparam logic [4:0] CP0_MT = 5'b00100;

  typedef enum logic {WrRt, WrRd} wr_sel_e;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/flush bundle between the ID stage and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
);
  logic              issue_valid;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rs_field;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic              retire_valid;
  logic [ADDR_W-1:0] retire_dest;
  logic              flush;
  logic              stall;
  logic              read_rs;
  logic              read_rt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_dest;
  logic [NUM_REGS-1:0] busy;
  logic              err_underflow;

  modport master (
    output issue_valid, op, funct, rs_field, rs, rt, rd, retire_valid, retire_dest, flush,
    input  stall, read_rs, read_rt, wr_en, wr_dest, busy, err_underflow
  );

  modport slave (
    input  issue_valid, op, funct, rs_field, rs, rt, rd, retire_valid, retire_dest, flush,
    output stall, read_rs, read_rt, wr_en, wr_dest, busy, err_underflow
  );
endinterface

// File: rtl/reg_access_decode.sv
// Combinational op/funct/rs_field decode into register reads, write enable and
// destination field select. Unknown encodings neither read nor write.
module reg_access_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rs_field,
  output logic       read_rs,
  output logic       read_rt,
  output logic       wr_en,
  output wr_sel_e    wr_sel
);

  always_comb begin
    read_rs = 1'b0;
    read_rt = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = WrRt;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: begin
            read_rs = 1'b1;
            read_rt = 1'b1;
            wr_en   = 1'b1;
            wr_sel  = WrRd;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            read_rt = 1'b1;
            wr_en   = 1'b1;
            wr_sel  = WrRd;
          end
          FN_JR:   read_rs = 1'b1;
          default: ;
        endcase
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        read_rs = 1'b1;
        read_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
        read_rs = 1'b1;
        wr_en   = 1'b1;
      end
      OP_COP0: begin
        if (rs_field == CP0_MT) read_rt = 1'b1;
        if (rs_field == CP0_MF) wr_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage RAW scoreboard: per-register saturating pending-write counters and stall.
// Define REG_SCOREBOARD_BYPASS_EN to let a same-cycle final retire clear a source hazard.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                err_q, err_d;
  logic                dec_rs, dec_rt, dec_wr;
  wr_sel_e             wr_sel;
  logic [ADDR_W-1:0]   wr_dest;
  logic                wr_en;
  logic [CNT_W-1:0]    cnt_rs, cnt_rt, cnt_wd;
  logic                byp_rs, byp_rt;
  logic                hazard_rs, hazard_rt, sat, stall;
  logic                issue_fire, retire_fire;
  logic [NUM_REGS-1:0] busy;

  reg_access_decode u_decode (
    .op      (sb.op),
    .funct   (sb.funct),
    .rs_field(sb.rs_field),
    .read_rs (dec_rs),
    .read_rt (dec_rt),
    .wr_en   (dec_wr),
    .wr_sel  (wr_sel)
  );

  assign wr_dest = (wr_sel == WrRd) ? sb.rd : sb.rt;
  assign wr_en   = dec_wr && (wr_dest != '0);

  // Indices beyond NUM_REGS read as an idle counter.
  always_comb begin
    cnt_rs = '0;
    cnt_rt = '0;
    cnt_wd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ADDR_W'(i) == sb.rs)   cnt_rs = cnt_q[i];
      if (ADDR_W'(i) == sb.rt)   cnt_rt = cnt_q[i];
      if (ADDR_W'(i) == wr_dest) cnt_wd = cnt_q[i];
    end
  end

`ifdef REG_SCOREBOARD_BYPASS_EN
  assign byp_rs = sb.retire_valid && (sb.retire_dest == sb.rs) && (cnt_rs == CNT_W'(1));
  assign byp_rt = sb.retire_valid && (sb.retire_dest == sb.rt) && (cnt_rt == CNT_W'(1));
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  assign hazard_rs = dec_rs && (sb.rs != '0) && (cnt_rs != '0) && !byp_rs;
  assign hazard_rt = dec_rt && (sb.rt != '0) && (cnt_rt != '0) && !byp_rt;
  assign sat       = wr_en && (cnt_wd == CntMax);
  assign stall     = sb.issue_valid && !sb.flush && (hazard_rs || hazard_rt || sat);

  assign issue_fire  = sb.issue_valid && !stall && !sb.flush && wr_en;
  assign retire_fire = sb.retire_valid && (sb.retire_dest != '0) && !sb.flush;

  always_comb begin
    logic inc, dec;
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc      = issue_fire && (wr_dest == ADDR_W'(i));
      dec      = retire_fire && (sb.retire_dest == ADDR_W'(i));
      cnt_d[i] = cnt_q[i];
      if (sb.flush) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) busy[i] = (cnt_q[i] != '0);
  end

  assign sb.stall         = stall;
  assign sb.read_rs       = dec_rs;
  assign sb.read_rt       = dec_rt;
  assign sb.wr_en         = wr_en;
  assign sb.wr_dest       = wr_dest;
  assign sb.busy          = busy;
  assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; honours REG_SCOREBOARD_BYPASS_EN.
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  reg_scoreboard_if #(.NUM_REGS(32), .ADDR_W(5)) sb ();

  reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    sb.issue_valid  = 1'b0;
    sb.op           = 6'h00;
    sb.funct        = 6'h00;
    sb.rs_field     = 5'd0;
    sb.rs           = 5'd0;
    sb.rt           = 5'd0;
    sb.rd           = 5'd0;
    sb.retire_valid = 1'b0;
    sb.retire_dest  = 5'd0;
    sb.flush        = 1'b0;
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d);
    sb.issue_valid = 1'b1;
    sb.op          = o;
    sb.funct       = f;
    sb.rs_field    = s;
    sb.rs          = s;
    sb.rt          = t;
    sb.rd          = d;
  endtask

  task automatic retire(input logic [4:0] r);
    sb.retire_valid = 1'b1;
    sb.retire_dest  = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_busy", sb.busy, 0);
    check("rst_err", sb.err_underflow, 0);
    check("rst_stall", sb.stall, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD r3,r1,r2
    instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3); #1;
    check("add_rd_rs", sb.read_rs, 1);
    check("add_rd_rt", sb.read_rt, 1);
    check("add_wr_en", sb.wr_en, 1);
    check("add_wr_dest", sb.wr_dest, 3);
    check("add_stall", sb.stall, 0);
    tick();
    check("add_busy", sb.busy, 32'h8);
    // SUB r4,r3,r1 hits pending r3
    instr(6'h00, 6'h22, 5'd3, 5'd1, 5'd4); #1;
    check("sub_stall", sb.stall, 1);
    tick();
    check("sub_held_busy", sb.busy, 32'h8);
    retire(5'd3); #1;
    check("sub_stall_retire", sb.stall, Byp ? 0 : 1);
    tick();
    check("after_retire_busy", sb.busy, Byp ? 32'h10 : 32'h0);
    sb.retire_valid = 1'b0; #1;
    check("sub_stall_clear", sb.stall, 0);
    tick();
    check("sub_issued_busy", sb.busy, 32'h10);
    idle();
    for (int k = 0; k < (Byp ? 2 : 1); k++) begin
      retire(5'd4);
      tick();
    end
    idle(); #1;
    check("drain_busy", sb.busy, 0);
    check("drain_err", sb.err_underflow, 0);

    // ADDI r0,r1,5 and an r0 reader
    instr(6'h08, 6'h00, 5'd1, 5'd0, 5'd0); #1;
    check("addi_r0_wr_en", sb.wr_en, 0);
    check("addi_r0_rd_rs", sb.read_rs, 1);
    tick();
    check("addi_r0_busy", sb.busy, 0);
    instr(6'h2b, 6'h00, 5'd0, 5'd0, 5'd0); #1;
    check("sw_r0_stall", sb.stall, 0);
    check("sw_wr_en", sb.wr_en, 0);
    check("sw_rd_rt", sb.read_rt, 1);

    // Decode-only spot checks
    idle();
    instr(6'h3f, 6'h00, 5'd1, 5'd2, 5'd3); sb.issue_valid = 1'b0; #1;
    check("unk_decode", {sb.read_rs, sb.read_rt, sb.wr_en}, 3'b000);
    instr(6'h10, 6'h00, 5'd0, 5'd6, 5'd0); sb.issue_valid = 1'b0; #1;
    check("mfc0_decode", {sb.read_rs, sb.read_rt, sb.wr_en, sb.wr_dest}, {3'b001, 5'd6});
    instr(6'h10, 6'h00, 5'd4, 5'd6, 5'd0); sb.issue_valid = 1'b0; #1;
    check("mtc0_decode", {sb.read_rs, sb.read_rt, sb.wr_en}, 3'b010);
    instr(6'h00, 6'h08, 5'd31, 5'd0, 5'd0); sb.issue_valid = 1'b0; #1;
    check("jr_decode", {sb.read_rs, sb.read_rt, sb.wr_en}, 3'b100);
    instr(6'h00, 6'h00, 5'd0, 5'd2, 5'd9); sb.issue_valid = 1'b0; #1;
    check("sll_decode", {sb.read_rs, sb.read_rt, sb.wr_en, sb.wr_dest}, {3'b011, 5'd9});
    idle();

    // Saturation on r7
    instr(6'h08, 6'h00, 5'd1, 5'd7, 5'd0);
    repeat (3) tick();
    check("sat_busy", sb.busy, 32'h80);
    check("sat_stall", sb.stall, 1);
    tick();
    check("sat_held_busy", sb.busy, 32'h80);
    retire(5'd7); #1;
    check("sat_stall_retire", sb.stall, 1);
    tick();
    sb.retire_valid = 1'b0; #1;
    check("sat_stall_free", sb.stall, 0);
    tick();
    idle();
    retire(5'd7);
    repeat (3) tick();
    idle(); #1;
    check("sat_drain_busy", sb.busy, 0);
    check("sat_drain_err", sb.err_underflow, 0);

    // Same-cycle issue and retire on r5
    instr(6'h08, 6'h00, 5'd1, 5'd5, 5'd0);
    tick();
    retire(5'd5); #1;
    check("same_stall", sb.stall, 0);
    tick();
    check("same_busy", sb.busy, 32'h20);
    idle();
    retire(5'd5);
    tick();
    idle(); #1;
    check("same_drain_busy", sb.busy, 0);
    check("same_drain_err", sb.err_underflow, 0);

    // Underflow on r9
    retire(5'd9);
    tick();
    idle(); #1;
    check("uf_err", sb.err_underflow, 1);
    check("uf_busy", sb.busy, 0);
    tick();
    check("uf_err_sticky", sb.err_underflow, 1);

    // Flush with busy = 0xF0
    for (int r = 4; r < 8; r++) begin
      instr(6'h08, 6'h00, 5'd1, 5'(r), 5'd0);
      tick();
    end
    idle(); #1;
    check("flush_pre_busy", sb.busy, 32'hf0);
    instr(6'h00, 6'h22, 5'd4, 5'd5, 5'd8);
    retire(5'd4);
    sb.flush = 1'b1; #1;
    check("flush_stall", sb.stall, 0);
    tick();
    idle(); #1;
    check("flush_busy", sb.busy, 0);

    // Async reset mid-stall
    instr(6'h08, 6'h00, 5'd1, 5'd3, 5'd0);
    tick();
    check("pre_rst_busy", sb.busy, 32'h8);
    instr(6'h00, 6'h22, 5'd3, 5'd1, 5'd4); #1;
    check("pre_rst_stall", sb.stall, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", sb.busy, 0);
    check("mid_rst_err", sb.err_underflow, 0);
    check("mid_rst_stall", sb.stall, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
